// File: rtl/uart_tx_arbiter_if.sv
// Handshake bundle between the byte-stream requesters, the arbiter and the UART TX serializer.
// master = arbiter side, slave = requesters/transmitter side.
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8
);
    localparam int ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_last;
    logic [NUM_REQ-1:0]        req_ready;
    logic [DATA_W-1:0]         tx_data;
    logic                      tx_start;
    logic                      tx_busy;
    logic [ID_W-1:0]           grant_id;
    logic                      grant_active;

    modport master (
        input  req_valid, req_data, req_last, tx_busy,
        output req_ready, tx_data, tx_start, grant_id, grant_active
    );

    modport slave (
        output req_valid, req_data, req_last, tx_busy,
        input  req_ready, tx_data, tx_start, grant_id, grant_active
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ byte-stream requesters;
// the grant is held across a multi-byte packet until its last byte has been sent.
module uart_tx_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    uart_tx_arbiter_if.master bus
);
    localparam int ID_W = $clog2(NUM_REQ);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_ACK,
        WAIT_DONE,
        HOLD
    } state_e;

    state_e            state_q;
    logic [ID_W-1:0]   grant_id_q;
    logic [ID_W-1:0]   rr_ptr_q;
    logic [DATA_W-1:0] tx_data_q;
    logic              tx_start_q;
    logic              last_q;
    logic              grant_active_q;

    logic [ID_W-1:0]    winner;
    logic               any_valid;
    logic [ID_W-1:0]    cand_id;
    int unsigned        cand;
    logic [DATA_W-1:0]  sel_data;
    logic               sel_last;
    logic [ID_W-1:0]    rr_next;
    logic [NUM_REQ-1:0] ready;

    // First valid requester at or above rr_ptr, wrapping past NUM_REQ-1 to 0.
    always_comb begin
        winner    = '0;
        any_valid = 1'b0;
        cand      = 0;
        cand_id   = '0;
        for (int unsigned off = 0; off < NUM_REQ; off++) begin
            cand    = (32'(rr_ptr_q) + off) % 32'(NUM_REQ);
            cand_id = ID_W'(cand);
            if (!any_valid && bus.req_valid[cand_id]) begin
                any_valid = 1'b1;
                winner    = cand_id;
            end
        end
    end

    always_comb begin
        sel_data = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (ID_W'(i) == grant_id_q) begin
                sel_data = bus.req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    assign sel_last = bus.req_last[grant_id_q];
    assign rr_next  = (grant_id_q == ID_W'(NUM_REQ - 1)) ? '0 : grant_id_q + 1'b1;

    always_comb begin
        ready = '0;
        if (state_q == ISSUE) begin
            ready[grant_id_q] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            grant_id_q     <= '0;
            rr_ptr_q       <= '0;
            tx_data_q      <= '0;
            tx_start_q     <= 1'b0;
            last_q         <= 1'b0;
            grant_active_q <= 1'b0;
        end else begin
            tx_start_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (any_valid) begin
                        grant_id_q     <= winner;
                        grant_active_q <= 1'b1;
                        state_q        <= ISSUE;
                    end
                end
                ISSUE: begin
                    tx_data_q  <= sel_data;
                    last_q     <= sel_last;
                    tx_start_q <= 1'b1;
                    state_q    <= WAIT_ACK;
                end
                WAIT_ACK: begin
                    if (bus.tx_busy) begin
                        state_q <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    if (!bus.tx_busy) begin
                        if (last_q) begin
                            rr_ptr_q       <= rr_next;
                            grant_active_q <= 1'b0;
                            state_q        <= IDLE;
                        end else begin
                            state_q <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    // Packet lock: only the owner can move us back to ISSUE.
                    if (bus.req_valid[grant_id_q]) begin
                        state_q <= ISSUE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.req_ready    = ready;
    assign bus.tx_data      = tx_data_q;
    assign bus.tx_start     = tx_start_q;
    assign bus.grant_id     = grant_id_q;
    assign bus.grant_active = grant_active_q;
endmodule
